// File: rtl/dev_uart_bridge.sv
`timescale 1ns/1ps
// Device-side stand-in for the tape reader/punch: bridges the 5-bit
// dev_input/dev_output 4-phase handshakes to a host over UART 8N1.
module dev_uart_bridge #(
  parameter int CLK_DIV = 868
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       uart_rx,
  output logic       uart_tx,
  input  logic       dev_input_rdy,
  output logic       dev_input_val,
  output logic [4:0] dev_input_data,
  input  logic       dev_output_rdy,
  output logic       dev_output_ack,
  input  logic [4:0] dev_output_data,
  output logic       rx_frame_err,
  output logic       rx_overrun
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {IN_IDLE, IN_SETUP, IN_VAL} in_state_t;
  typedef enum logic [1:0] {OUT_IDLE, OUT_SEND, OUT_ACK} out_state_t;

  logic uart_rx_meta, uart_rx_s, uart_rx_q;
  logic in_rdy_meta, dev_input_rdy_s;
  logic out_rdy_meta, dev_output_rdy_s;

  rx_state_t        rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_idx;
  logic [7:0]       rx_shift;
  logic             buf_full;
  logic [4:0]       buf_word;

  tx_state_t        tx_state;
  logic [CNT_W-1:0] tx_cnt;
  logic [2:0]       tx_idx;
  logic [7:0]       tx_shift;
  logic             tx_done;

  in_state_t  in_state;
  out_state_t out_state;

  logic buf_free;
  logic tx_load;

  assign buf_free = (in_state == IN_VAL) && !dev_input_rdy_s;
  assign tx_load  = (out_state == OUT_IDLE) && dev_output_rdy_s;

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      uart_rx_meta     <= 1'b1;
      uart_rx_s        <= 1'b1;
      uart_rx_q        <= 1'b1;
      in_rdy_meta      <= 1'b0;
      dev_input_rdy_s  <= 1'b0;
      out_rdy_meta     <= 1'b0;
      dev_output_rdy_s <= 1'b0;
    end else begin
      uart_rx_meta     <= uart_rx;
      uart_rx_s        <= uart_rx_meta;
      uart_rx_q        <= uart_rx_s;
      in_rdy_meta      <= dev_input_rdy;
      dev_input_rdy_s  <= in_rdy_meta;
      out_rdy_meta     <= dev_output_rdy;
      dev_output_rdy_s <= out_rdy_meta;
    end
  end

  // Receiver plus the one-byte buffer it fills; the detect cycle already counts
  // as one cycle past the synchronized edge, hence rx_cnt starts at 1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      buf_full     <= 1'b0;
      buf_word     <= '0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
      if (buf_free) buf_full <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (uart_rx_q && !uart_rx_s) begin
            rx_cnt   <= CNT_ONE;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= uart_rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {uart_rx_s, rx_shift[7:1]};
            if (rx_idx == 3'd7) rx_state <= RX_STOP;
            else                rx_idx   <= rx_idx + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (!uart_rx_s) begin
              rx_frame_err <= 1'b1;
            end else if (buf_full) begin
              rx_overrun <= 1'b1;
            end else begin
              buf_word <= rx_shift[4:0];
              buf_full <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_ONE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      in_state       <= IN_IDLE;
      dev_input_val  <= 1'b0;
      dev_input_data <= '0;
    end else begin
      case (in_state)
        IN_IDLE: begin
          if (buf_full && dev_input_rdy_s) begin
            dev_input_data <= buf_word;
            in_state       <= IN_SETUP;
          end
        end
        IN_SETUP: begin
          dev_input_val <= 1'b1;
          in_state      <= IN_VAL;
        end
        IN_VAL: begin
          if (!dev_input_rdy_s) begin
            dev_input_val <= 1'b0;
            in_state      <= IN_IDLE;
          end
        end
        default: begin
          dev_input_val <= 1'b0;
          in_state      <= IN_IDLE;
        end
      endcase
    end
  end

  // Transmitter loads on the same edge the output handshake captures the word,
  // so the start bit appears without an extra cycle of latency.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state <= TX_IDLE;
      uart_tx  <= 1'b1;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (tx_state)
        TX_IDLE: begin
          if (tx_load) begin
            tx_shift <= {3'b000, dev_output_data};
            uart_tx  <= 1'b0;
            tx_cnt   <= '0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == BIT_LAST) begin
            uart_tx  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_cnt   <= '0;
            tx_idx   <= '0;
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              uart_tx  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
              tx_idx   <= tx_idx + 3'd1;
            end
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        TX_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx_done  <= 1'b1;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + CNT_ONE;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_state      <= OUT_IDLE;
      dev_output_ack <= 1'b0;
    end else begin
      case (out_state)
        OUT_IDLE: if (tx_load) out_state <= OUT_SEND;
        OUT_SEND: begin
          if (tx_done) begin
            dev_output_ack <= 1'b1;
            out_state      <= OUT_ACK;
          end
        end
        OUT_ACK: begin
          if (!dev_output_rdy_s) begin
            dev_output_ack <= 1'b0;
            out_state      <= OUT_IDLE;
          end
        end
        default: begin
          dev_output_ack <= 1'b0;
          out_state      <= OUT_IDLE;
        end
      endcase
    end
  end

endmodule
